// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: FSM states, decoded op kinds, default width.
package muldiv_pkg;
  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  typedef enum logic [2:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  } op_kind_e;
endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step on a {hi,lo} accumulator.
// Divide branch exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic               mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;

  // Multiplier sits in the low half and is consumed LSB first as the product shifts in from the top.
  assign mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
  assign mul_acc = {mul_sum, acc_i[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] trial;

  assign trial  = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
  assign qbit_o = mode_i & ~trial[WIDTH];

  // The vacated LSB is left zero; the caller merges the quotient bit into it.
  always_comb begin
    acc_o = mul_acc;
    if (mode_i) begin
      acc_o = {(qbit_o ? trial[WIDTH-1:0] : acc_i[2*WIDTH-2:WIDTH-1]), acc_i[WIDTH-2:0], 1'b0};
    end
  end
`else
  assign qbit_o = 1'b0;
  assign acc_o  = mode_i ? acc_i : mul_acc;
`endif
endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning HI/LO; stalls the pipe until the result retires.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU strobes are ignored and dz stays 0.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_mult,
  input  logic             op_multu,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic             op_mthi,
  input  logic             op_mtlo,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);
`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  localparam int unsigned   CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  state_e             state_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
  logic               div_q, neg_q, rneg_q, dzp_q, dz_q;

  op_kind_e           req;
  logic               is_mul, is_div, is_signed, rs_neg, rt_neg, div_zero;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] step_acc, acc_nxt, prod;
  logic               step_qbit;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    req = OP_NONE;
    if (op_div && DivEn)       req = OP_DIV;
    else if (op_divu && DivEn) req = OP_DIVU;
    else if (op_mult)          req = OP_MULT;
    else if (op_multu)         req = OP_MULTU;
    else if (op_mthi)          req = OP_MTHI;
    else if (op_mtlo)          req = OP_MTLO;
  end

  assign is_div    = (req == OP_DIV) || (req == OP_DIVU);
  assign is_mul    = (req == OP_MULT) || (req == OP_MULTU);
  assign is_signed = (req == OP_MULT) || (req == OP_DIV);
  assign rs_neg    = is_signed & rs_data[WIDTH-1];
  assign rt_neg    = is_signed & rt_data[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_data : rs_data;
  assign rt_mag    = rt_neg ? -rt_data : rt_data;
  assign div_zero  = is_div && (rt_data == '0);

  assign stall = (state_q == CALC) || ((state_q == IDLE) && (is_mul || is_div));
  assign done  = (state_q == FIX);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_i (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .qbit_o (step_qbit)
  );
  assign acc_nxt = step_acc | {{(2*WIDTH-1){1'b0}}, step_qbit};

  // Sign fix-up on the magnitude result; a divide-by-zero leaves both flags clear.
  assign prod   = neg_q ? -acc_q : acc_q;
  assign quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign fix_hi = div_q ? rem : prod[2*WIDTH-1:WIDTH];
  assign fix_lo = div_q ? quo : prod[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dzp_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req == OP_MTHI) hi_q <= rs_data;
          if (req == OP_MTLO) lo_q <= rs_data;
          if (is_mul || is_div) begin
            count_q <= '0;
            div_q   <= is_div;
            opnd_q  <= is_div ? rt_mag : rs_mag;
            if (div_zero) begin
              acc_q   <= {rs_data, {WIDTH{1'b1}}};
              neg_q   <= 1'b0;
              rneg_q  <= 1'b0;
              dzp_q   <= 1'b1;
              state_q <= FIX;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, (is_div ? rs_mag : rt_mag)};
              neg_q   <= rs_neg ^ rt_neg;
              rneg_q  <= rs_neg;
              dzp_q   <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q   <= acc_nxt;
          count_q <= count_q + 1'b1;
          if (count_q == LastCnt) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          if (div_q) dz_q <= dzp_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
  assign dz = DivEn & dz_q;
endmodule
